rc5_core_param: RTL and testbench
=================================

Name: rc5_core_param

Overview:
- Parametrised RC5-W/R/b block cipher core for encryption and decryption.
- Word width W is configurable, giving a 2W-bit block. Round count R is configurable.
- The round-key table is runtime-loadable. Data moves through valid/ready handshakes on input and output.
- Iterative datapath: one half-round per clock. Sits between the host data path and the key-schedule unit.

Parameters:
- W, 8, half-block word width in bits; legal values 8, 16, 32; block = 2W bits
- R, 1, number of rounds; legal range 1..15; key table holds T = 2R+2 words
- LGW, $clog2(W), rotate-amount width (derived, not overridden)
- KAW, $clog2(2R+2), key-table address width (derived)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- key_we  in  1  key-table write strobe
- key_addr  in  KAW  key-table index S[i]
- key_wdata  in  W  key word
- in_valid  in  1  input block valid
- in_ready  out  1  core can accept a block
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with block
- in_block  in  2W  input block; A = [2W-1:W], B = [W-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_block  out  2W  result block, same A/B layout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, while reset = 0):
  - state = IDLE; out_valid = 0; out_block = 0; in_ready = 1; busy = 0.
  - All key-table words = 0; round counter = 0.
- States: IDLE, PRE, HALF_A, HALF_B, POST, DONE.
- Handshake: accept on the rising edge where in_valid and in_ready are both 1.
  - in_ready = (state == IDLE).
  - Accept latches A, B and mode; goes to PRE (encrypt) or HALF_B (decrypt).
- Arithmetic:
  - All add/sub is modulo 2^W.
  - rotl/rotr amount = low LGW bits of the other word; amount 0 leaves the value unchanged (no shift by W).
- Encrypt sequence:
  - PRE: A = A + S[0]; B = B + S[1]; i = 1.
  - HALF_A: A = rotl(A ^ B, B) + S[2i].
  - HALF_B: B = rotl(B ^ A, A) + S[2i+1]. If i == R, go to DONE; else i++ and go to HALF_A.
- Decrypt sequence (i starts at R):
  - HALF_B: B = rotr(B - S[2i+1], A) ^ A.
  - HALF_A: A = rotr(A - S[2i], B) ^ B. If i == 1, go to POST; else i-- and go to HALF_B.
  - POST: B = B - S[1]; A = A - S[0]; go to DONE.
- Latency: exactly 2R+1 clocks from the accept edge to the edge that sets out_valid = 1, for both modes.
  - The entry into DONE drives out_block = {A, B} and out_valid = 1.
- DONE:
  - Hold out_block and out_valid stable until out_ready = 1.
  - On the edge with out_valid & out_ready: out_valid = 0; state = IDLE.
  - The next block is not accepted on that same edge; in_ready rises the following cycle.
- Key writes:
  - A key_we edge writes S[key_addr] = key_wdata only when state == IDLE.
  - Writes while busy are ignored, so the table is stable during a block.
  - key_addr >= T: write ignored.
  - Simultaneous key_we and block accept in IDLE: the write takes effect, and the block uses the new value only if it is first read after that edge. Every S read happens at or after PRE/HALF_B, so the new value is always used.
- Reset mid-operation: state is aborted immediately, outputs return to reset values, and the key table is cleared. The host must reload keys.
- Compatibility: W = 8, R = 1 with S = {20,10,FF,FF} is bit-exact with the existing 16-bit encryptor.

Optional Feature:
- Macro: RC5_BLK_CNT_EN.
- Defined:
  - Adds output blk_cnt [15:0]. It increments on every out_valid & out_ready edge, wraps FFFF -> 0000, and resets to 0.
  - Adds input cnt_clr [0:0], which synchronously zeroes the counter. If cnt_clr and an increment coincide, the result is 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Basic encrypt: W=8, R=1, load S={20,10,FF,FF}, encrypt 0x0000 -> out_block 0x2F9E, out_valid exactly 3 clocks after accept. Encrypt 0x1234 -> 0x6687.
- Decrypt round-trip: decrypt 0x2F9E -> 0x0000 and 0x6687 -> 0x1234 with the same latency. Repeat for W=16, R=12 with random keys, checking 500 random blocks against a reference model for enc then dec identity.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out_block stable at 0x2F9E, in_ready = 0, busy = 1. Release -> out_valid drops next edge, in_ready = 1 the cycle after.
- Key protection: key_we S[2] = 0x00 during HALF_A of a block -> result still 0x2F9E. The same write in IDLE changes the next ciphertext of 0x0000 to 0x30 in the A byte (A = 0x30 + 0x00).
- Reset mid-operation: assert reset during HALF_B -> out_valid = 0, out_block = 0, in_ready = 1 asynchronously. After release, read-back ciphertext of 0x0000 with an unloaded (zero) table -> 0x0000.
- RC5_BLK_CNT_EN: complete 3 blocks -> blk_cnt = 3. Pulse cnt_clr coincident with a 4th completion -> blk_cnt = 0.

Source files
------------

// File: rtl/rc5_core_param.sv
// Iterative RC5-W/R/b encrypt/decrypt core: one half-round per clock, runtime-loadable round-key table.
// Optional macro RC5_BLK_CNT_EN adds a completed-block counter (blk_cnt) with synchronous clear (cnt_clr).
module rc5_core_param #(
    parameter int W = 8,
    parameter int R = 1,
    localparam int LGW = $clog2(W),
    localparam int KAW = $clog2(2*R+2)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           key_we,
    input  logic [KAW-1:0] key_addr,
    input  logic [W-1:0]   key_wdata,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [2*W-1:0] in_block,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_block,
    output logic           busy
`ifdef RC5_BLK_CNT_EN
    ,
    input  logic           cnt_clr,
    output logic [15:0]    blk_cnt
`endif
);

    localparam int T = 2*R+2;

    typedef enum logic [2:0] {IDLE, PRE, HALF_A, HALF_B, POST, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           mode_q, mode_d;
    logic [KAW-1:0] i_q, i_d;
    logic [2*W-1:0] out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   key_q [T];
    logic [T-1:0]   key_sel;
    logic           key_wr_en;

    logic [KAW:0]   two_i;
    logic [W-1:0]   k_even, k_odd;
    logic [W-1:0]   a_enc, b_enc, a_dec, b_dec;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    // Writes only land in IDLE so the table is frozen for the whole block.
    assign key_wr_en = key_we && (state_q == IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < T; gi++) begin : g_key_sel
            assign key_sel[gi] = key_wr_en && (key_addr == KAW'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < T; k++) key_q[k] <= '0;
        end else begin
            for (int k = 0; k < T; k++) begin
                if (key_sel[k]) key_q[k] <= key_wdata;
            end
        end
    end

    assign two_i  = {i_q, 1'b0};
    assign k_even = key_q[two_i[KAW-1:0]];
    assign k_odd  = key_q[two_i[KAW-1:0] | KAW'(1)];

    assign a_enc = rotl(a_q ^ b_q, b_q[LGW-1:0]) + k_even;
    assign b_enc = rotl(b_q ^ a_q, a_q[LGW-1:0]) + k_odd;
    assign b_dec = rotr(b_q - k_odd, a_q[LGW-1:0]) ^ a_q;
    assign a_dec = rotr(a_q - k_even, b_q[LGW-1:0]) ^ b_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        i_d         = i_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = in_block[2*W-1:W];
                    b_d    = in_block[W-1:0];
                    mode_d = in_mode;
                    if (in_mode) begin
                        i_d     = KAW'(R);
                        state_d = HALF_B;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                a_d     = a_q + key_q[0];
                b_d     = b_q + key_q[1];
                i_d     = KAW'(1);
                state_d = HALF_A;
            end
            HALF_A: begin
                if (!mode_q) begin
                    a_d     = a_enc;
                    state_d = HALF_B;
                end else begin
                    a_d = a_dec;
                    if (i_q == KAW'(1)) begin
                        state_d = POST;
                    end else begin
                        i_d     = i_q - KAW'(1);
                        state_d = HALF_B;
                    end
                end
            end
            HALF_B: begin
                if (!mode_q) begin
                    b_d = b_enc;
                    if (i_q == KAW'(R)) begin
                        out_d       = {a_q, b_enc};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        i_d     = i_q + KAW'(1);
                        state_d = HALF_A;
                    end
                end else begin
                    b_d     = b_dec;
                    state_d = HALF_A;
                end
            end
            POST: begin
                a_d         = a_q - key_q[0];
                b_d         = b_q - key_q[1];
                out_d       = {a_q - key_q[0], b_q - key_q[1]};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            i_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_block = out_q;

`ifdef RC5_BLK_CNT_EN
    logic [15:0] cnt_q;

    // Clear wins over a coincident completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign blk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rc5_core_param.sv
// Bench for rc5_core_param: directed W=8/R=1 checks plus random W=8/R=1 and W=16/R=12 blocks vs a behavioural RC5 model.
module tb_rc5_core_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    // W=8, R=1 instance
    logic        r8;
    logic        k8_we;
    logic [1:0]  k8_addr;
    logic [7:0]  k8_wdata;
    logic        i8_valid, i8_ready, i8_mode;
    logic [15:0] i8_block;
    logic        o8_valid, o8_ready;
    logic [15:0] o8_block;
    logic        busy8;
`ifdef RC5_BLK_CNT_EN
    logic        clr8;
    logic [15:0] cnt8;
`endif

    // W=16, R=12 instance
    logic        r16;
    logic        k16_we;
    logic [4:0]  k16_addr;
    logic [15:0] k16_wdata;
    logic        i16_valid, i16_ready, i16_mode;
    logic [31:0] i16_block;
    logic        o16_valid, o16_ready;
    logic [31:0] o16_block;
    logic        busy16;
`ifdef RC5_BLK_CNT_EN
    logic        clr16;
    logic [15:0] cnt16;
`endif

    rc5_core_param #(.W(8), .R(1)) dut8 (
        .clock(clock), .reset(r8),
        .key_we(k8_we), .key_addr(k8_addr), .key_wdata(k8_wdata),
        .in_valid(i8_valid), .in_ready(i8_ready), .in_mode(i8_mode), .in_block(i8_block),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_block(o8_block),
        .busy(busy8)
`ifdef RC5_BLK_CNT_EN
        , .cnt_clr(clr8), .blk_cnt(cnt8)
`endif
    );

    rc5_core_param #(.W(16), .R(12)) dut16 (
        .clock(clock), .reset(r16),
        .key_we(k16_we), .key_addr(k16_addr), .key_wdata(k16_wdata),
        .in_valid(i16_valid), .in_ready(i16_ready), .in_mode(i16_mode), .in_block(i16_block),
        .out_valid(o16_valid), .out_ready(o16_ready), .out_block(o16_block),
        .busy(busy16)
`ifdef RC5_BLK_CNT_EN
        , .cnt_clr(clr16), .blk_cnt(cnt16)
`endif
    );

    longint unsigned s8  [32];
    longint unsigned s16 [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint unsigned mrotl(longint unsigned x, longint unsigned amt, int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned wl   = longint'(w);
        int n = int'(amt % wl);
        if (n == 0) return x & mask;
        return ((x << n) | (x >> (w - n))) & mask;
    endfunction

    function automatic longint unsigned mrotr(longint unsigned x, longint unsigned amt, int w);
        longint unsigned wl = longint'(w);
        int n = int'(amt % wl);
        return mrotl(x, longint'((w - n) % w), w);
    endfunction

    // Textbook RC5 on plain integers; sel16 picks which key table to use.
    function automatic longint unsigned rc5_ref(bit sel16, int w, int r, bit dec, longint unsigned blk);
        longint unsigned m = (64'd1 << w) - 64'd1;
        longint unsigned sk [32];
        longint unsigned a, b;
        for (int k = 0; k < 32; k++) sk[k] = sel16 ? s16[k] : s8[k];
        a = (blk >> w) & m;
        b = blk & m;
        if (!dec) begin
            a = (a + sk[0]) & m;
            b = (b + sk[1]) & m;
            for (int i = 1; i <= r; i++) begin
                a = (mrotl(a ^ b, b, w) + sk[2*i]) & m;
                b = (mrotl(b ^ a, a, w) + sk[2*i+1]) & m;
            end
        end else begin
            for (int i = r; i >= 1; i--) begin
                b = mrotr((b - sk[2*i+1]) & m, a, w) ^ a;
                a = mrotr((a - sk[2*i]) & m, b, w) ^ b;
            end
            b = (b - sk[1]) & m;
            a = (a - sk[0]) & m;
        end
        return (a << w) | b;
    endfunction

    task automatic key8(input int addr, input int data);
        k8_we = 1'b1; k8_addr = 2'(addr); k8_wdata = 8'(data);
        s8[addr] = longint'(data & 8'hFF);
        @(posedge clock); #1;
        k8_we = 1'b0;
    endtask

    task automatic key16(input int addr, input int data);
        k16_we = 1'b1; k16_addr = 5'(addr); k16_wdata = 16'(data);
        s16[addr] = longint'(data & 16'hFFFF);
        @(posedge clock); #1;
        k16_we = 1'b0;
    endtask

    task automatic run8(input string tag, input bit mode, input logic [15:0] blk,
                        input logic [15:0] exp, input int hold, input bit poke,
                        input bit clr, output logic [15:0] got);
        int n = 0;
        while (!i8_ready && n < 50) begin @(posedge clock); #1; n++; end
        i8_valid = 1'b1; i8_mode = mode; i8_block = blk;
        @(posedge clock); #1;
        i8_valid = 1'b0;
        n = 0;
        while (!o8_valid && n < 100) begin
            k8_we = (poke && n == 1);
            k8_addr = 2'd2; k8_wdata = 8'h00;
            @(posedge clock); #1;
            n++;
        end
        k8_we = 1'b0;
        got = o8_block;
        $display("txn %s mode=%0d in=%h out=%h lat=%0d", tag, mode, blk, o8_block, n);
        chk({tag, " latency"}, 64'(n), 64'd3);
        chk({tag, " block"}, 64'(o8_block), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk({tag, " hold block"}, 64'(o8_block), 64'(exp));
        end
        if (hold > 0) begin
            chk({tag, " hold valid"}, 64'(o8_valid), 64'd1);
            chk({tag, " hold in_ready"}, 64'(i8_ready), 64'd0);
            chk({tag, " hold busy"}, 64'(busy8), 64'd1);
        end
        o8_ready = 1'b1;
`ifdef RC5_BLK_CNT_EN
        clr8 = clr;
`endif
        @(posedge clock); #1;
        o8_ready = 1'b0;
`ifdef RC5_BLK_CNT_EN
        clr8 = 1'b0;
`endif
        chk({tag, " valid drop"}, 64'(o8_valid), 64'd0);
        chk({tag, " in_ready back"}, 64'(i8_ready), 64'(!clr || clr));
    endtask

    task automatic run16(input string tag, input bit mode, input logic [31:0] blk, input logic [31:0] exp);
        int n = 0;
        while (!i16_ready && n < 50) begin @(posedge clock); #1; n++; end
        i16_valid = 1'b1; i16_mode = mode; i16_block = blk;
        @(posedge clock); #1;
        i16_valid = 1'b0;
        n = 0;
        while (!o16_valid && n < 200) begin @(posedge clock); #1; n++; end
        $display("txn %s mode=%0d in=%h out=%h lat=%0d", tag, mode, blk, o16_block, n);
        chk({tag, " latency"}, 64'(n), 64'd25);
        chk({tag, " block"}, 64'(o16_block), 64'(exp));
        o16_ready = 1'b1;
        @(posedge clock); #1;
        o16_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] got8;
        logic [15:0] b8, e8;
        logic [31:0] b32, e32;

        r8 = 1'b0; r16 = 1'b0;
        k8_we = 0; k8_addr = 0; k8_wdata = 0;
        i8_valid = 0; i8_mode = 0; i8_block = 0; o8_ready = 0;
        k16_we = 0; k16_addr = 0; k16_wdata = 0;
        i16_valid = 0; i16_mode = 0; i16_block = 0; o16_ready = 0;
`ifdef RC5_BLK_CNT_EN
        clr8 = 0; clr16 = 0;
`endif
        for (int k = 0; k < 32; k++) begin s8[k] = 0; s16[k] = 0; end
        repeat (3) @(posedge clock);
        #1;
        chk("reset out_valid", 64'(o8_valid), 64'd0);
        chk("reset out_block", 64'(o8_block), 64'd0);
        chk("reset in_ready", 64'(i8_ready), 64'd1);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset busy16", 64'(busy16), 64'd0);
        r8 = 1'b1; r16 = 1'b1;
        @(posedge clock); #1;

        key8(0, 'h20); key8(1, 'h10); key8(2, 'hFF); key8(3, 'hFF);
        run8("enc 0000", 0, 16'h0000, 16'h2F9E, 0, 0, 0, got8);
        run8("enc 1234", 0, 16'h1234, 16'h6687, 0, 0, 0, got8);
        run8("dec 2F9E", 1, 16'h2F9E, 16'h0000, 0, 0, 0, got8);
        run8("dec 6687", 1, 16'h6687, 16'h1234, 0, 0, 0, got8);
        run8("backpressure", 0, 16'h0000, 16'h2F9E, 5, 0, 0, got8);
        run8("busy key write", 0, 16'h0000, 16'h2F9E, 0, 1, 0, got8);

        key8(2, 'h00);
        run8("idle key write", 0, 16'h0000, 16'(rc5_ref(0, 8, 1, 0, 0)), 0, 0, 0, got8);
        chk("idle key write A byte", 64'(got8[15:8]), 64'h30);

        for (int k = 0; k < 4; k++) key8(k, int'($urandom_range(0, 255)));
        for (int t = 0; t < 20; t++) begin
            b8 = 16'($urandom_range(0, 65535));
            e8 = 16'(rc5_ref(0, 8, 1, 0, longint'(b8)));
            run8("rnd8 enc", 0, b8, e8, 0, 0, 0, got8);
            run8("rnd8 dec", 1, e8, b8, 0, 0, 0, got8);
        end

        for (int k = 0; k < 26; k++) key16(k, int'($urandom_range(0, 65535)));
        for (int t = 0; t < 500; t++) begin
            b32 = $urandom;
            e32 = 32'(rc5_ref(1, 16, 12, 0, longint'(b32)));
            run16("rnd16 enc", 0, b32, e32);
            run16("rnd16 dec", 1, e32, b32);
        end

        // Abort a block in HALF_B with an asynchronous reset.
        key8(0, 'h20); key8(1, 'h10); key8(2, 'hFF); key8(3, 'hFF);
        i8_valid = 1'b1; i8_mode = 1'b0; i8_block = 16'h0000;
        @(posedge clock); #1;
        i8_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("midop busy before reset", 64'(busy8), 64'd1);
        #2 r8 = 1'b0;
        #1;
        $display("txn midop reset out_valid=%0d out_block=%h in_ready=%0d", o8_valid, o8_block, i8_ready);
        chk("midop reset out_valid", 64'(o8_valid), 64'd0);
        chk("midop reset out_block", 64'(o8_block), 64'd0);
        chk("midop reset in_ready", 64'(i8_ready), 64'd1);
        chk("midop reset busy", 64'(busy8), 64'd0);
`ifdef RC5_BLK_CNT_EN
        chk("midop reset blk_cnt", 64'(cnt8), 64'd0);
`endif
        @(posedge clock); #1;
        r8 = 1'b1;
        for (int k = 0; k < 32; k++) s8[k] = 0;
        @(posedge clock); #1;
        run8("zero table enc", 0, 16'h0000, 16'h0000, 0, 0, 0, got8);

`ifdef RC5_BLK_CNT_EN
        run8("cnt blk2", 0, 16'hA5A5, 16'(rc5_ref(0, 8, 1, 0, 64'hA5A5)), 0, 0, 0, got8);
        run8("cnt blk3", 0, 16'h0F0F, 16'(rc5_ref(0, 8, 1, 0, 64'h0F0F)), 0, 0, 0, got8);
        chk("blk_cnt after 3", 64'(cnt8), 64'd3);
        run8("cnt blk4 clr", 0, 16'h1234, 16'(rc5_ref(0, 8, 1, 0, 64'h1234)), 0, 0, 1, got8);
        chk("blk_cnt clr wins", 64'(cnt8), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
